mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS-subset datapath: PC, instruction memory, register file, sign/zero extender, ALU, plus a data memory. It replaces the single-cycle combinational decoder with a state machine. Each instruction is split into fetch/decode/execute/memory/write-back steps, so the datapath registers are written only in the cycle the controller enables them. It sits beside the datapath and takes opcode/funct from the instruction register and `zero` from the ALU. It drives every write enable and mux select.

## Interface
Parameters: none. Encodings are fixed constants in the shared package.
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clock
- op  in  6  instruction[31:26], from the instruction register
- funct  in  6  instruction[5:0], from the instruction register
- zero  in  1  ALU result == 0
- pc_write  out  1  load PC from the next-PC mux
- npc_sel  out  2  next-PC source: 00 = pc+4, 01 = branch target, 10 = jump target
- ir_write  out  1  load instruction register
- reg_write  out  1  register-file write enable
- regdst  out  1  1 = write rd, 0 = write rt
- extop  out  1  1 = sign-extend, 0 = zero-extend
- alusrc  out  1  1 = extended immediate, 0 = rt data
- aluop  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LUI (b<<16)
- mem_write  out  1  data-memory write enable
- mem_to_reg  out  1  1 = register write data comes from data memory
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported op/funct

## Operation
- Supported instructions:
  - R-type (op 000000) with funct: addu 100001, subu 100011, and 100100, or 100101, slt 101010
  - addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010
- States: FETCH, DECODE, EXE_R, EXE_I, EXE_M, MEM_RD, MEM_WR, WB_R, WB_I, WB_M, BRANCH, JUMP.
- FETCH: ir_write=1, pc_write=1, npc_sel=00. Next state DECODE.
- DECODE: no writes. Next state by op:
  - R-type with a legal funct → EXE_R
  - addiu/ori/lui → EXE_I
  - lw/sw → EXE_M
  - beq → BRANCH
  - j → JUMP
  - anything else → FETCH, with illegal=1 and instr_done=1
- EXE_R: alusrc=0, aluop from funct. Next state WB_R.
- WB_R: reg_write=1, regdst=1, ALU select held, instr_done=1. Next state FETCH.
- EXE_I: alusrc=1, with per-instruction settings:
  - addiu: extop=1, ADD
  - ori: extop=0, OR
  - lui: extop=0, LUI
  - Next state WB_I.
- WB_I: reg_write=1, regdst=0, EXE_I settings held, instr_done=1. Next state FETCH.
- EXE_M: alusrc=1, extop=1, ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: address held (alusrc=1, extop=1, ADD). Next state WB_M.
- WB_M: reg_write=1, regdst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEM_WR: mem_write=1, address held, instr_done=1. Next state FETCH.
- BRANCH: alusrc=0, SUB, extop=1, npc_sel=01, pc_write=zero, instr_done=1. Next state FETCH.
- JUMP: npc_sel=10, pc_write=1, instr_done=1. Next state FETCH.
- Outputs are Moore-decoded from state and op/funct. The single exception is pc_write in BRANCH, which also depends on zero.
- Every output not listed for a state is 0.
- No undriven states: unused state encodings go to FETCH on the next edge.

## Timing
- Reset:
  - Asserting reset forces state=FETCH on the next edge, including in the middle of an instruction; any partial instruction is abandoned and none of its remaining writes occur.
  - While reset is high, every output is held at 0, including FETCH's ir_write and pc_write.
  - Fetch starts on the first edge after reset falls.
- Cycles per instruction:
  - 4: R-type, I-type ALU, sw
  - 5: lw
  - 3: beq, j
  - 2: illegal
- instr_done is high exactly once per instruction, in the final state. The next cycle is always FETCH.
- op/funct are sampled every cycle. They are stable from DECODE onward because ir_write is asserted only in FETCH.

## Structure
- Package `mc_pkg` holds:
  - the state enum
  - opcode and funct constants
  - aluop constants (ALU_ADD … ALU_LUI)
  - npc_sel constants
- Single module; no sub-module. An output-decode function for the ALU selects (aluop/extop/alusrc) lives in `mc_pkg` and is shared with the ALU testbench.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; the first post-reset cycle shows ir_write=1, pc_write=1.
- op=000000, funct=100011 (subu) → state sequence FETCH, DECODE, EXE_R, WB_R. In WB_R: reg_write=1, regdst=1, aluop=001, instr_done=1.
- op=100011 (lw) → 5 cycles; WB_M shows mem_to_reg=1, reg_write=1, regdst=0. Repeat with op=101011 (sw) → 4 cycles, mem_write=1 only in MEM_WR, reg_write never high.
- op=000100 (beq) with zero=1 → BRANCH has pc_write=1, npc_sel=01. With zero=0 → pc_write=0, and FETCH follows in both cases.
- op=111111 → illegal=1 and instr_done=1 in DECODE, then FETCH; no reg_write or mem_write at any point.
- Reset asserted during MEM_RD of lw → next state FETCH; reg_write never asserted for that lw.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// funct codes, ALU/next-PC selects and the ALU-select decode shared with the ALU bench.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXE_R  = 4'd2,
        EXE_I  = 4'd3,
        EXE_M  = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_R   = 4'd7,
        WB_I   = 4'd8,
        WB_M   = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    typedef struct packed {
        logic [2:0] aluop;
        logic       extop;
        logic       alusrc;
    } alu_sel_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_AND) ||
               (funct == FN_OR)   || (funct == FN_SLT);
    endfunction

    function automatic logic [2:0] funct_to_aluop(input logic [5:0] funct);
        logic [2:0] a;
        case (funct)
            FN_SUBU: a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // ALU operand/operation selects are held steady across every state of an
    // instruction that keeps the ALU result live (address, write-back value).
    function automatic alu_sel_t decode_alu_sel(input state_t st, input logic [5:0] op,
                                                input logic [5:0] funct);
        alu_sel_t s;
        s = '0;
        case (st)
            EXE_R, WB_R: s.aluop = funct_to_aluop(funct);
            EXE_I, WB_I: begin
                s.alusrc = 1'b1;
                case (op)
                    OP_ADDIU: begin s.extop = 1'b1; s.aluop = ALU_ADD; end
                    OP_ORI:   s.aluop = ALU_OR;
                    OP_LUI:   s.aluop = ALU_LUI;
                    default:  s.aluop = ALU_ADD;
                endcase
            end
            EXE_M, MEM_RD, MEM_WR: begin
                s.alusrc = 1'b1;
                s.extop  = 1'b1;
                s.aluop  = ALU_ADD;
            end
            BRANCH: begin
                s.extop = 1'b1;
                s.aluop = ALU_SUB;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: sequences fetch/decode/execute/memory/write-back and
// drives every datapath write enable and mux select from the current state.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic [1:0] npc_sel,
    output logic       ir_write,
    output logic       reg_write,
    output logic       regdst,
    output logic       extop,
    output logic       alusrc,
    output logic [2:0] aluop,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal
);

    state_t   state;
    state_t   next_state;
    alu_sel_t sel;

    assign sel = decode_alu_sel(state, op, funct);

    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        pc_write   = 1'b0;
        npc_sel    = NPC_SEQ;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        regdst     = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        aluop      = sel.aluop;
        extop      = sel.extop;
        alusrc     = sel.alusrc;

        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct_legal(funct)) next_state = EXE_R;
                        else begin illegal = 1'b1; instr_done = 1'b1; end
                    end
                    OP_ADDIU, OP_ORI, OP_LUI: next_state = EXE_I;
                    OP_LW, OP_SW:             next_state = EXE_M;
                    OP_BEQ:                   next_state = BRANCH;
                    OP_J:                     next_state = JUMP;
                    default: begin illegal = 1'b1; instr_done = 1'b1; end
                endcase
            end
            EXE_R:  next_state = WB_R;
            EXE_I:  next_state = WB_I;
            EXE_M:  next_state = (op == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: next_state = WB_M;
            WB_R: begin
                reg_write  = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            WB_M: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                npc_sel    = NPC_BR;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            JUMP: begin
                npc_sel    = NPC_JMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        // Reset silences the datapath entirely, FETCH's enables included.
        if (reset) begin
            pc_write   = 1'b0;
            npc_sel    = NPC_SEQ;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            regdst     = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
            aluop      = 3'b000;
            extop      = 1'b0;
            alusrc     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each driven cycle pushes its expected output
// vector, and a negedge monitor pops and compares it against the DUT.
module tb_mc_ctrl;

    logic       clock;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic [1:0] npc_sel;
    logic       ir_write;
    logic       reg_write;
    logic       regdst;
    logic       extop;
    logic       alusrc;
    logic [2:0] aluop;
    logic       mem_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;

    typedef struct {
        string       tag;
        logic [14:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    mc_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pc_write   (pc_write),
        .npc_sel    (npc_sel),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .regdst     (regdst),
        .extop      (extop),
        .alusrc     (alusrc),
        .aluop      (aluop),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Vector order: pc_write npc_sel ir_write reg_write regdst extop alusrc aluop mem_write mem_to_reg instr_done illegal
    function automatic logic [14:0] mk(input logic pcw, input logic [1:0] npc, input logic irw,
                                       input logic rw, input logic rd, input logic ext,
                                       input logic src, input logic [2:0] aop, input logic mw,
                                       input logic m2r, input logic done, input logic ill);
        return {pcw, npc, irw, rw, rd, ext, src, aop, mw, m2r, done, ill};
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] actual, input logic [14:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b required %b", tag, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput(e.tag, {pc_write, npc_sel, ir_write, reg_write, regdst, extop, alusrc,
                                aluop, mem_write, mem_to_reg, instr_done, illegal}, e.vec);
        end
    end

    // Entered at posedge+1 with this cycle's inputs set; leaves at the next posedge+1.
    task automatic step(input string tag, input logic [14:0] vec);
        exp_t e;
        e.tag = tag;
        e.vec = vec;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input string name, input logic [5:0] o, input logic [5:0] f,
                                 input logic z);
        logic [2:0] ra;
        logic       legal_r;
        op    = o;
        funct = f;
        zero  = z;
        legal_r = 1'b1;
        case (f)
            6'b100001: ra = 3'b000;
            6'b100011: ra = 3'b001;
            6'b100100: ra = 3'b010;
            6'b100101: ra = 3'b011;
            6'b101010: ra = 3'b100;
            default: begin ra = 3'b000; legal_r = 1'b0; end
        endcase
        step({name, ":FETCH"}, mk(1, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
        case (o)
            6'b000000: begin
                if (legal_r) begin
                    step({name, ":DECODE"}, '0);
                    step({name, ":EXE_R"}, mk(0, 2'b00, 0, 0, 0, 0, 0, ra, 0, 0, 0, 0));
                    step({name, ":WB_R"},  mk(0, 2'b00, 0, 1, 1, 0, 0, ra, 0, 0, 1, 0));
                end else begin
                    step({name, ":DECODE"}, mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1));
                end
            end
            6'b001001, 6'b001101, 6'b001111: begin
                logic       ie;
                logic [2:0] ia;
                ie = (o == 6'b001001);
                ia = (o == 6'b001001) ? 3'b000 : (o == 6'b001101) ? 3'b011 : 3'b101;
                step({name, ":DECODE"}, '0);
                step({name, ":EXE_I"}, mk(0, 2'b00, 0, 0, 0, ie, 1, ia, 0, 0, 0, 0));
                step({name, ":WB_I"},  mk(0, 2'b00, 0, 1, 0, ie, 1, ia, 0, 0, 1, 0));
            end
            6'b100011: begin
                step({name, ":DECODE"}, '0);
                step({name, ":EXE_M"},  mk(0, 2'b00, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0));
                step({name, ":MEM_RD"}, mk(0, 2'b00, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0));
                step({name, ":WB_M"},   mk(0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 0, 1, 1, 0));
            end
            6'b101011: begin
                step({name, ":DECODE"}, '0);
                step({name, ":EXE_M"},  mk(0, 2'b00, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0));
                step({name, ":MEM_WR"}, mk(0, 2'b00, 0, 0, 0, 1, 1, 3'b000, 1, 0, 1, 0));
            end
            6'b000100: begin
                step({name, ":DECODE"}, '0);
                step({name, ":BRANCH"}, mk(z, 2'b01, 0, 0, 0, 1, 0, 3'b001, 0, 0, 1, 0));
            end
            6'b000010: begin
                step({name, ":DECODE"}, '0);
                step({name, ":JUMP"}, mk(1, 2'b10, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0));
            end
            default: step({name, ":DECODE"}, mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1));
        endcase
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) step($sformatf("reset%0d", i), '0);
        reset = 1'b0;

        applyStimulus("subu",   6'b000000, 6'b100011, 1'b1);
        applyStimulus("addu",   6'b000000, 6'b100001, 1'b0);
        applyStimulus("and",    6'b000000, 6'b100100, 1'b1);
        applyStimulus("or",     6'b000000, 6'b100101, 1'b0);
        applyStimulus("slt",    6'b000000, 6'b101010, 1'b1);
        applyStimulus("addiu",  6'b001001, 6'b101010, 1'b0);
        applyStimulus("ori",    6'b001101, 6'b000000, 1'b1);
        applyStimulus("lui",    6'b001111, 6'b100011, 1'b0);
        applyStimulus("lw",     6'b100011, 6'b000000, 1'b1);
        applyStimulus("sw",     6'b101011, 6'b100001, 1'b1);
        applyStimulus("beq_z1", 6'b000100, 6'b000000, 1'b1);
        applyStimulus("beq_z0", 6'b000100, 6'b000000, 1'b0);
        applyStimulus("j",      6'b000010, 6'b000000, 1'b1);
        applyStimulus("ill_op", 6'b111111, 6'b100001, 1'b0);
        applyStimulus("ill_fn", 6'b000000, 6'b000000, 1'b1);
        applyStimulus("addu2",  6'b000000, 6'b100001, 1'b1);

        // lw abandoned by a reset during MEM_RD: no write-back may follow.
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        step("lwrst:FETCH",  mk(1, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
        step("lwrst:DECODE", '0);
        step("lwrst:EXE_M",  mk(0, 2'b00, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0));
        reset = 1'b1;
        step("lwrst:MEM_RD", '0);
        reset = 1'b0;
        applyStimulus("after_rst", 6'b000000, 6'b100101, 1'b0);
        applyStimulus("sw2",       6'b101011, 6'b000000, 1'b0);

        checkOutput("queue_drained", 15'(exp_q.size()), 15'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
